// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversion helpers.
package fifo_pkg;

  localparam int DEFAULT_ADDR_SIZE = 4;
  localparam int DEFAULT_DEPTH     = 1 << DEFAULT_ADDR_SIZE;

  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Helpers work on 32-bit values; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    for (int i = 31; i >= 0; i--) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter, shared by both FIFO pointer domains.
module gray_to_binary #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/write_pointer_generation.sv
// Write-domain pointer, full/almost-full and level logic for the async FIFO.
// Optional sticky overflow flag is built when WRT_OVERFLOW_FLAG_EN is defined.
module write_pointer_generation
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int AF_MARGIN = 2
) (
  input  logic                 wrt_clk,
  input  logic                 wrt_rst,
  input  logic                 wrt_ena,
  input  logic [ADDR_SIZE:0]   sync_rd_ptr,
  output logic                 wrt_accept,
  output logic [ADDR_SIZE-1:0] wrt_addr,
  output logic [ADDR_SIZE:0]   wrt_ptr,
  output logic                 wrt_full,
  output logic                 wrt_almost_full,
  output logic [ADDR_SIZE:0]   wrt_level,
  output logic                 wrt_overflow
);

  localparam int DEPTH = depth_of(ADDR_SIZE);
  localparam int PW    = ADDR_SIZE + 1;

  logic [PW-1:0] wrt_bin_q, wrt_bin_d;
  logic [PW-1:0] wrt_ptr_q, wrt_ptr_d;
  logic [PW-1:0] wrt_level_q, wrt_level_d;
  logic          wrt_full_q, wrt_full_d;
  logic          wrt_af_q, wrt_af_d;
  logic [PW-1:0] rd_bin_sync;

  gray_to_binary #(.WIDTH(PW)) u_rd_g2b (
    .gray_i (sync_rd_ptr),
    .bin_o  (rd_bin_sync)
  );

  assign wrt_accept = wrt_ena & ~wrt_full_q;

  always_comb begin
    wrt_bin_d   = wrt_bin_q + {{ADDR_SIZE{1'b0}}, wrt_accept};
    wrt_ptr_d   = PW'(bin2gray(32'(wrt_bin_d)));
    wrt_level_d = wrt_bin_d - rd_bin_sync;
    // Full when the write pointer is one whole lap ahead: top two Gray bits inverted.
    wrt_full_d  = (wrt_ptr_d == {~sync_rd_ptr[PW-1:PW-2], sync_rd_ptr[PW-3:0]});
    wrt_af_d    = (int'(wrt_level_d) >= DEPTH - AF_MARGIN);
  end

  always_ff @(posedge wrt_clk or posedge wrt_rst) begin
    if (wrt_rst) begin
      wrt_bin_q   <= '0;
      wrt_ptr_q   <= '0;
      wrt_level_q <= '0;
      wrt_full_q  <= 1'b0;
      wrt_af_q    <= 1'b0;
    end else begin
      wrt_bin_q   <= wrt_bin_d;
      wrt_ptr_q   <= wrt_ptr_d;
      wrt_level_q <= wrt_level_d;
      wrt_full_q  <= wrt_full_d;
      wrt_af_q    <= wrt_af_d;
    end
  end

  assign wrt_addr        = wrt_bin_q[ADDR_SIZE-1:0];
  assign wrt_ptr         = wrt_ptr_q;
  assign wrt_level       = wrt_level_q;
  assign wrt_full        = wrt_full_q;
  assign wrt_almost_full = wrt_af_q;

`ifdef WRT_OVERFLOW_FLAG_EN
  logic wrt_ovf_q, wrt_ovf_d;

  always_comb begin
    wrt_ovf_d = wrt_ovf_q | (wrt_ena & wrt_full_q);
  end

  always_ff @(posedge wrt_clk or posedge wrt_rst) begin
    if (wrt_rst) wrt_ovf_q <= 1'b0;
    else         wrt_ovf_q <= wrt_ovf_d;
  end

  assign wrt_overflow = wrt_ovf_q;
`else
  assign wrt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_generation.sv
// Bench for write_pointer_generation (ADDR_SIZE=4, AF_MARGIN=2) against a count-based model.
module tb_write_pointer_generation;

  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic       wrt_clk = 1'b0;
  logic       wrt_rst;
  logic       wrt_ena;
  logic [4:0] sync_rd_ptr;
  logic       wrt_accept;
  logic [3:0] wrt_addr;
  logic [4:0] wrt_ptr;
  logic       wrt_full;
  logic       wrt_almost_full;
  logic [4:0] wrt_level;
  logic       wrt_overflow;

  write_pointer_generation #(.ADDR_SIZE(4), .AF_MARGIN(AFM)) dut (
    .wrt_clk         (wrt_clk),
    .wrt_rst         (wrt_rst),
    .wrt_ena         (wrt_ena),
    .sync_rd_ptr     (sync_rd_ptr),
    .wrt_accept      (wrt_accept),
    .wrt_addr        (wrt_addr),
    .wrt_ptr         (wrt_ptr),
    .wrt_full        (wrt_full),
    .wrt_almost_full (wrt_almost_full),
    .wrt_level       (wrt_level),
    .wrt_overflow    (wrt_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 wrt_clk = ~wrt_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: total writes accepted and total reads seen, as plain integers.
  int m_wr  = 0;
  int rd_cnt = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;
  logic [3:0] exp_q[$];

  function automatic logic [4:0] gray_of(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int m_level();
    return m_wr - rd_cnt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_rd(input int r);
    rd_cnt      = r;
    sync_rd_ptr = gray_of(r);
  endtask

  task automatic tick();
    bit acc;
    acc = wrt_ena && !m_full;
`ifdef WRT_OVERFLOW_FLAG_EN
    if (wrt_ena && m_full) m_ovf = 1'b1;
`endif
    @(posedge wrt_clk);
    #1;
    if (acc) m_wr++;
    m_full = (m_level() == DEPTH);
  endtask

  task automatic do_reset();
    wrt_ena = 1'b0;
    set_rd(0);
    wrt_rst = 1'b1;
    @(posedge wrt_clk);
    #1;
    wrt_rst = 1'b0;
    m_wr = 0;
    m_full = 1'b0;
    m_ovf = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({wrt_ptr, wrt_level, wrt_addr, wrt_full, wrt_almost_full, wrt_overflow} !== 17'd0) begin
      n_err++;
      $display("FAIL reset: ptr=%b level=%0d addr=%0d full=%b af=%b ovf=%b, want all 0",
               wrt_ptr, wrt_level, wrt_addr, wrt_full, wrt_almost_full, wrt_overflow);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_addr;
    do_reset();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(4'(i));
    wrt_ena = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      exp_addr = exp_q.pop_front();
      n_vec++;
      if (wrt_addr !== exp_addr || wrt_accept !== 1'b1) begin
        n_err++;
        $display("FAIL fill_addr[%0d]: addr=%0d accept=%b, want addr=%0d accept=1",
                 i, wrt_addr, wrt_accept, exp_addr);
      end
      tick();
      n_vec++;
      if (wrt_level !== 5'(i + 1) || wrt_full !== (i == DEPTH - 1) ||
          wrt_almost_full !== (i + 1 >= DEPTH - AFM) || wrt_ptr !== gray_of(i + 1)) begin
        n_err++;
        $display("FAIL fill_flags[%0d]: level=%0d full=%b af=%b ptr=%b, want level=%0d full=%b af=%b ptr=%b",
                 i, wrt_level, wrt_full, wrt_almost_full, wrt_ptr, i + 1,
                 (i == DEPTH - 1), (i + 1 >= DEPTH - AFM), gray_of(i + 1));
      end
    end
    n_vec++;
    if (wrt_ptr !== 5'b11000 || wrt_level !== 5'd16) begin
      n_err++;
      $display("FAIL fill_final: ptr=%b level=%0d, want 11000 16", wrt_ptr, wrt_level);
    end
  endtask

  task automatic test_overflow();
    wrt_ena = 1'b1;
    #1;
    n_vec++;
    if (wrt_accept !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_accept: accept=%b, want 0", wrt_accept);
    end
    tick();
    n_vec++;
    if (wrt_ptr !== 5'b11000 || wrt_full !== 1'b1 || wrt_overflow !== m_ovf) begin
      n_err++;
      $display("FAIL ovf_state: ptr=%b full=%b ovf=%b, want 11000 1 %b",
               wrt_ptr, wrt_full, wrt_overflow, m_ovf);
    end
  endtask

  task automatic test_drain();
    wrt_ena = 1'b0;
    set_rd(4);
    tick();
    n_vec++;
    if (wrt_full !== 1'b0 || wrt_level !== 5'd12 || wrt_almost_full !== 1'b0 ||
        wrt_overflow !== m_ovf) begin
      n_err++;
      $display("FAIL drain: full=%b level=%0d af=%b ovf=%b, want 0 12 0 %b",
               wrt_full, wrt_level, wrt_almost_full, wrt_overflow, m_ovf);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    int exp_lvl;
    do_reset();
    prev = wrt_ptr;
    wrt_ena = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_rd((m_wr + 1 - 3 < 0) ? 0 : m_wr + 1 - 3);
      tick();
      exp_lvl = (i + 1 < 3) ? i + 1 : 3;
      n_vec++;
      if (wrt_level !== 5'(exp_lvl) || wrt_full !== 1'b0 || wrt_ptr !== gray_of(i + 1) ||
          $countones(prev ^ wrt_ptr) != 1) begin
        n_err++;
        $display("FAIL wrap[%0d]: level=%0d full=%b ptr=%b prev=%b, want level=%0d full=0 ptr=%b",
                 i, wrt_level, wrt_full, wrt_ptr, prev, exp_lvl, gray_of(i + 1));
      end
      prev = wrt_ptr;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wrt_ena = 1'b1;
    repeat (15) tick();
    for (int r = 1; r <= 2; r++) begin
      set_rd(r);
      tick();
      n_vec++;
      if (wrt_level !== 5'd15 || wrt_full !== 1'b0 || wrt_almost_full !== 1'b1) begin
        n_err++;
        $display("FAIL same_cycle[rd=%0d]: level=%0d full=%b af=%b, want 15 0 1",
                 r, wrt_level, wrt_full, wrt_almost_full);
      end
    end
  endtask

  task automatic test_random();
    int adv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wrt_ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        adv = rd_cnt + $urandom_range(0, 3);
        set_rd((adv > m_wr) ? m_wr : adv);
      end
      #1;
      n_vec++;
      if (wrt_accept !== (wrt_ena && !m_full)) begin
        n_err++;
        $display("FAIL rand_accept[%0d]: accept=%b, want %b", i, wrt_accept, wrt_ena && !m_full);
      end
      tick();
      n_vec++;
      if (wrt_level !== 5'(m_level()) || wrt_full !== m_full ||
          wrt_almost_full !== (m_level() >= DEPTH - AFM) || wrt_ptr !== gray_of(m_wr) ||
          wrt_addr !== 4'(m_wr) || wrt_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL rand[%0d]: level=%0d full=%b af=%b ptr=%b addr=%0d ovf=%b, want %0d %b %b %b %0d %b",
                 i, wrt_level, wrt_full, wrt_almost_full, wrt_ptr, wrt_addr, wrt_overflow,
                 m_level(), m_full, (m_level() >= DEPTH - AFM), gray_of(m_wr), m_wr % 16, m_ovf);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wrt_ena = 1'b1;
    repeat (9) tick();
    n_vec++;
    if (wrt_level !== 5'd9) begin
      n_err++;
      $display("FAIL arst_pre: level=%0d, want 9", wrt_level);
    end
    #2;
    wrt_rst = 1'b1;
    #1;
    n_vec++;
    if ({wrt_ptr, wrt_level, wrt_addr, wrt_full, wrt_almost_full, wrt_overflow} !== 17'd0) begin
      n_err++;
      $display("FAIL arst: ptr=%b level=%0d addr=%0d full=%b af=%b ovf=%b, want all 0",
               wrt_ptr, wrt_level, wrt_addr, wrt_full, wrt_almost_full, wrt_overflow);
    end
    wrt_ena = 1'b0;
    @(posedge wrt_clk);
    #1;
    wrt_rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    wrt_rst = 1'b1;
    wrt_ena = 1'b0;
    sync_rd_ptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
